// File: rtl/gon_y_bus_feeder.sv
// gon_y_bus_feeder
// Source stage for the GON Y-bus, directly upstream of the column of Y
// multicast controllers.
//   - CFG: shifts one row ID per cycle into the controller scan chain
//     (set_id / id_out). The farthest controller's ID goes out first.
//   - RUN: a small FIFO buffers (row tag, column tag, value) packets from the
//     global buffer. The head is presented on the shared Y-bus and popped
//     when the addressed controller returns ready.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cfg_start, cfg_ids  ID-load request and packed per-controller row IDs
//   set_id, id_out      scan-chain shift enable and data into controller 0
//   cfg_done            one-cycle pulse after the last shift
//   in_valid/in_ready   upstream packet handshake
//   in_row_tag, in_col_tag, in_value   upstream packet fields
//   bus_enable/bus_ready                Y-bus handshake
//   bus_tag, bus_col_tag, bus_value     Y-bus packet fields (0 when idle)
//   fifo_count          FIFO occupancy, 0..FIFO_DEPTH
//   state_idle          high in IDLE
module gon_y_bus_feeder #(
    parameter int ROW_LEN    = 4,
    parameter int ID_LEN     = 5,
    parameter int VALUE_LEN  = 32,
    parameter int NUM_ROWS   = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_start,
    input  logic [NUM_ROWS*ROW_LEN-1:0]   cfg_ids,
    output logic                          set_id,
    output logic [ROW_LEN-1:0]            id_out,
    output logic                          cfg_done,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ROW_LEN-1:0]            in_row_tag,
    input  logic [ID_LEN-1:0]             in_col_tag,
    input  logic [VALUE_LEN-1:0]          in_value,
    output logic [ROW_LEN-1:0]            bus_tag,
    output logic                          bus_enable,
    input  logic                          bus_ready,
    output logic [VALUE_LEN-1:0]          bus_value,
    output logic [ID_LEN-1:0]             bus_col_tag,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          state_idle
);

    localparam int SW  = NUM_ROWS * ROW_LEN;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int NW  = $clog2(NUM_ROWS + 1);
    localparam int PKW = ROW_LEN + ID_LEN + VALUE_LEN;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CFG,
        S_RUN
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sr_q, sr_d;
    logic [NW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;

    logic [PKW-1:0]  mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            push, pop;
    logic [PKW-1:0]  head;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    state_d = S_CFG;
                    sr_d    = cfg_ids;
                    cnt_d   = '0;
                end
            end
            S_CFG: begin
                // Top slice is on id_out; shift the next one up each cycle.
                sr_d = sr_q << ROW_LEN;
                if (cnt_q == NW'(NUM_ROWS - 1)) begin
                    state_d = S_RUN;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + NW'(1);
                end
            end
            S_RUN: begin
                // Reconfigure only with nothing buffered or on the bus.
                if (cfg_start && count_q == '0) begin
                    state_d = S_CFG;
                    sr_d    = cfg_ids;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign set_id     = (state_q == S_CFG);
    assign id_out     = set_id ? sr_q[SW-1 -: ROW_LEN] : '0;
    assign cfg_done   = done_q;
    assign state_idle = (state_q == S_IDLE);

    // ------------------------------------------------------------------
    // Packet FIFO
    // ------------------------------------------------------------------
    // in_ready looks only at occupancy, so a full FIFO refuses a push even
    // when a pop happens in the same cycle.
    assign in_ready   = (count_q != CW'(FIFO_DEPTH));
    assign push       = in_valid & in_ready;
    // bus_enable is a function of registered state only; bus_ready only
    // qualifies the pop, which keeps the controller loop combinationally open.
    assign bus_enable = (state_q == S_RUN) && (count_q != '0);
    assign pop        = bus_enable & bus_ready;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) wptr_d = wptr_q + PW'(1);
        if (pop)  rptr_d = rptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {in_row_tag, in_col_tag, in_value};
        end
    end

    assign head = mem_q[rptr_q];

    always_comb begin
        bus_tag     = '0;
        bus_col_tag = '0;
        bus_value   = '0;
        if (bus_enable) begin
            {bus_tag, bus_col_tag, bus_value} = head;
        end
    end

    assign fifo_count = count_q;

endmodule

// File: tb/tb_gon_y_bus_feeder.sv
// Testbench for gon_y_bus_feeder. A transaction-level model (packet queue,
// mode and shift index) predicts every output on every cycle. Directed
// scenarios are followed by a randomized phase.
module tb_gon_y_bus_feeder;

    localparam int RL = 4;
    localparam int IL = 5;
    localparam int VL = 32;
    localparam int NR = 6;
    localparam int FD = 4;

    localparam int M_IDLE = 0;
    localparam int M_CFG  = 1;
    localparam int M_RUN  = 2;

    logic              clk = 1'b0;
    logic              rst, cfg_start, in_valid, bus_ready;
    logic [NR*RL-1:0]  cfg_ids;
    logic [RL-1:0]     in_row_tag;
    logic [IL-1:0]     in_col_tag;
    logic [VL-1:0]     in_value;
    logic              set_id, cfg_done, in_ready, bus_enable, state_idle;
    logic [RL-1:0]     id_out, bus_tag;
    logic [IL-1:0]     bus_col_tag;
    logic [VL-1:0]     bus_value;
    logic [$clog2(FD):0] fifo_count;

    always #5 clk = ~clk;

    gon_y_bus_feeder #(
        .ROW_LEN   (RL),
        .ID_LEN    (IL),
        .VALUE_LEN (VL),
        .NUM_ROWS  (NR),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_start  (cfg_start),
        .cfg_ids    (cfg_ids),
        .set_id     (set_id),
        .id_out     (id_out),
        .cfg_done   (cfg_done),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_row_tag (in_row_tag),
        .in_col_tag (in_col_tag),
        .in_value   (in_value),
        .bus_tag    (bus_tag),
        .bus_enable (bus_enable),
        .bus_ready  (bus_ready),
        .bus_value  (bus_value),
        .bus_col_tag(bus_col_tag),
        .fifo_count (fifo_count),
        .state_idle (state_idle)
    );

    typedef struct {
        logic [RL-1:0] tag;
        logic [IL-1:0] col;
        logic [VL-1:0] val;
    } pkt_t;

    pkt_t          mq[$];
    int            m_mode;
    int            m_j;
    logic [RL-1:0] m_ids[NR];
    bit            m_done;

    logic [RL-1:0] chain[NR];
    int            setid_seen;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_load();
        for (int k = 0; k < NR; k++) m_ids[k] = cfg_ids[k*RL +: RL];
        m_j    = 0;
        m_mode = M_CFG;
    endtask

    // One clock cycle: check outputs mid-cycle, then advance the model
    // with the inputs present at the edge.
    task automatic step();
        bit   en, push, pop;
        int   sz;
        pkt_t h;
        #3;
        sz = mq.size();
        en = (m_mode == M_RUN) && (sz > 0);
        if (en) h = mq[0];
        else    h = '{tag: '0, col: '0, val: '0};
        check("in_ready",    64'(in_ready),    64'(sz < FD));
        check("bus_enable",  64'(bus_enable),  64'(en));
        check("bus_tag",     64'(bus_tag),     64'(h.tag));
        check("bus_col_tag", 64'(bus_col_tag), 64'(h.col));
        check("bus_value",   64'(bus_value),   64'(h.val));
        check("fifo_count",  64'(fifo_count),  64'(sz));
        check("state_idle",  64'(state_idle),  64'(m_mode == M_IDLE));
        check("set_id",      64'(set_id),      64'(m_mode == M_CFG));
        check("id_out",      64'(id_out),      (m_mode == M_CFG) ? 64'(m_ids[NR-1-m_j]) : 64'(0));
        check("cfg_done",    64'(cfg_done),    64'(m_done));
        if (set_id === 1'b1) begin
            setid_seen++;
            for (int k = NR - 1; k > 0; k--) chain[k] = chain[k-1];
            chain[0] = id_out;
        end
        @(posedge clk);
        if (rst) begin
            m_mode = M_IDLE;
            mq.delete();
            m_done = 0;
            m_j    = 0;
        end else begin
            push   = in_valid && (sz < FD);
            pop    = en && bus_ready;
            m_done = 0;
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back('{tag: in_row_tag, col: in_col_tag, val: in_value});
            case (m_mode)
                M_IDLE: if (cfg_start) model_load();
                M_CFG: begin
                    if (m_j == NR - 1) begin
                        m_mode = M_RUN;
                        m_done = 1;
                        m_j    = 0;
                    end else begin
                        m_j++;
                    end
                end
                default: if (cfg_start && sz == 0) model_load();
            endcase
        end
        #1;
    endtask

    task automatic drive(input bit r, input bit cs, input bit v, input logic [RL-1:0] t,
                         input logic [IL-1:0] c, input logic [VL-1:0] val, input bit br);
        rst        = r;
        cfg_start  = cs;
        in_valid   = v;
        in_row_tag = t;
        in_col_tag = c;
        in_value   = val;
        bus_ready  = br;
        step();
    endtask

    initial begin
        int seen0;
        rst = 1; cfg_start = 0; in_valid = 0; bus_ready = 0;
        cfg_ids = '0; in_row_tag = '0; in_col_tag = '0; in_value = '0;
        setid_seen = 0;
        for (int k = 0; k < NR; k++) chain[k] = '0;
        @(posedge clk);
        #1;
        m_mode = M_IDLE; m_j = 0; m_done = 0; mq.delete();

        // Reset held a second cycle, then idle.
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0);

        // Configuration: slices 0..5 = 1..6.
        for (int k = 0; k < NR; k++) cfg_ids[k*RL +: RL] = RL'(k + 1);
        seen0 = setid_seen;
        drive(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < NR + 2; i++) drive(0, 0, 0, 0, 0, 0, 0);
        check("cfg_setid_cycles", 64'(setid_seen - seen0), 64'(NR));
        for (int k = 0; k < NR; k++) check("scan_chain", 64'(chain[k]), 64'(k + 1));

        // Single packet with bus_ready tied high.
        drive(0, 0, 1, 4'd3, 5'd7, 32'hDEADBEEF, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 1);

        // Backpressure: 5 pushes, 4 accepted, then drain.
        for (int i = 1; i <= 5; i++) drive(0, 0, 1, RL'(i), IL'(i), VL'(i), 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 0, 0, 1);

        // Simultaneous push/pop at occupancy 2.
        for (int i = 0; i < 2; i++) drive(0, 0, 1, RL'(8 + i), IL'(20 + i), VL'(100 + i), 0);
        for (int i = 0; i < 6; i++) drive(0, 0, 1, RL'(i), IL'(i + 10), VL'(200 + i), 1);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 1);

        // cfg_start with packets buffered is ignored.
        for (int i = 0; i < 2; i++) drive(0, 0, 1, RL'(i), IL'(i), VL'(300 + i), 0);
        seen0 = setid_seen;
        drive(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0);
        check("cfg_ignored", 64'(setid_seen - seen0), 64'(0));
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 1);

        // Reset on the third set_id cycle abandons the load.
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 4'd1, 5'd1, 32'h55, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("rst_mid_cfg_idle", 64'(state_idle), 64'(1));

        // Randomized traffic, reconfiguration and occasional reset.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) cfg_ids = NR*RL'($urandom);
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 2) != 0,
                  RL'($urandom), IL'($urandom), $urandom,
                  $urandom_range(0, 2) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
